// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback and drives
// ALU and datapath selects; memory states wait on mem_ready with a bounded timeout.
module mc_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] ALU_op,
   output logic       ALU_src_a,
   output logic [1:0] ALU_src_b,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       illegal_op,
   output logic       bus_err,
   output logic [3:0] state_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StExecR   = 4'd3,
      StRWb     = 4'd4,
      StMemAddr = 4'd5,
      StMemRd   = 4'd6,
      StLdWb    = 4'd7,
      StMemWr   = 4'd8,
      StBranch  = 4'd9,
      StJump    = 4'd10,
      StAddiEx  = 4'd11,
      StAddiWb  = 4'd12
   } state_e;

   localparam logic [5:0] OpRType = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpAddi  = 6'h08;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              mem_state;
   logic              timeout;

   assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
   assign timeout   = mem_state && !mem_ready && (cnt_q == CntW'(TIMEOUT));
   assign state_o   = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter only runs while stalled in a memory state; any exit or timeout restarts it at 0.
   always_comb begin
      cnt_d = '0;
      if (mem_state && !mem_ready && !timeout) cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   state_d = StFetch;
         StFetch:  if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpRType:     state_d = StExecR;
               OpLw, OpSw:  state_d = StMemAddr;
               OpBeq:       state_d = StBranch;
               OpJ:         state_d = StJump;
               OpAddi:      state_d = StAddiEx;
               default:     state_d = StFetch;
            endcase
         end
         StExecR:   state_d = StRWb;
         StRWb:     state_d = StFetch;
         StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
         StMemRd: begin
            if (mem_ready)    state_d = StLdWb;
            else if (timeout) state_d = StFetch;
         end
         StLdWb:    state_d = StFetch;
         StMemWr:   if (mem_ready || timeout) state_d = StFetch;
         StBranch:  state_d = StFetch;
         StJump:    state_d = StFetch;
         StAddiEx:  state_d = StAddiWb;
         StAddiWb:  state_d = StFetch;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      ALU_op     = 2'b00;
      ALU_src_a  = 1'b0;
      ALU_src_b  = 2'b00;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      illegal_op = 1'b0;
      bus_err    = timeout;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            ALU_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         StDecode: begin
            ALU_src_b  = 2'b11;
            illegal_op = !(opcode inside {OpRType, OpLw, OpSw, OpBeq, OpJ, OpAddi});
         end
         StExecR: begin
            ALU_src_a = 1'b1;
            ALU_op    = 2'b10;
         end
         StRWb: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         StMemAddr, StAddiEx: begin
            ALU_src_a = 1'b1;
            ALU_src_b = 2'b10;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StLdWb: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         StBranch: begin
            ALU_src_a = 1'b1;
            ALU_op    = 2'b01;
            pc_src    = 2'b01;
            pc_en     = zero;
         end
         StJump: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         StAddiWb: reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class, the memory stall/timeout
// boundary and an asynchronous abort, comparing against hand-computed values.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [1:0] ALU_op;
   logic       ALU_src_a;
   logic [1:0] ALU_src_b;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic [1:0] pc_src;
   logic       pc_en;
   logic       illegal_op;
   logic       bus_err;
   logic [3:0] state_o;

   int total = 0;
   int bad   = 0;

   mc_ctrl_fsm #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .ALU_op     (ALU_op),
      .ALU_src_a  (ALU_src_a),
      .ALU_src_b  (ALU_src_b),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .pc_src     (pc_src),
      .pc_en      (pc_en),
      .illegal_op (illegal_op),
      .bus_err    (bus_err),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int all_outs();
      return int'({ALU_op, ALU_src_a, ALU_src_b, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, pc_src, pc_en, illegal_op, bus_err});
   endfunction

   int errs;

   initial begin
      rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      step(); step();
      check("reset_state", int'(state_o), 0);
      check("reset_outs", all_outs(), 0);
      rst = 1'b0;
      #1;
      check("idle_after_release", int'(state_o), 0);

      // add
      step();
      check("fetch_state", int'(state_o), 1);
      check("fetch_sel", int'({mem_read, i_or_d, ALU_src_a, ALU_src_b, ALU_op}), 'b1_0_0_01_00);
      check("fetch_ir_pc", int'({ir_write, pc_en}), 3);
      step();
      check("decode_state", int'(state_o), 2);
      check("decode_srcb", int'(ALU_src_b), 3);
      step();
      check("execr_state", int'(state_o), 3);
      check("execr_aluop", int'(ALU_op), 2);
      step();
      check("rwb_state", int'(state_o), 4);
      check("rwb_write", int'({reg_write, reg_dst, mem_to_reg}), 'b110);
      opcode = 6'h23;
      step();
      check("back_to_fetch", int'(state_o), 1);

      // lw with 3 wait cycles in MEM_RD
      step(); step();
      check("memaddr_state", int'(state_o), 5);
      check("memaddr_sel", int'({ALU_src_a, ALU_src_b, ALU_op}), 'b1_10_00);
      mem_ready = 1'b0;
      step(); step(); step();
      check("memrd_hold", int'(state_o), 6);
      check("memrd_sel", int'({mem_read, i_or_d, reg_write}), 'b110);
      mem_ready = 1'b1;
      #1;
      check("memrd_no_buserr", int'(bus_err), 0);
      step();
      check("ldwb_state", int'(state_o), 7);
      check("ldwb_write", int'({reg_write, mem_to_reg, reg_dst}), 'b110);

      // beq taken, then not taken
      opcode = 6'h04; zero = 1'b1;
      step(); step(); step();
      check("beq_state", int'(state_o), 9);
      check("beq_taken", int'({pc_en, pc_src, ALU_op}), 'b1_01_01);
      zero = 1'b0;
      #1;
      check("beq_not_taken", int'(pc_en), 0);
      step(); step(); step();
      check("beq2_state", int'(state_o), 9);
      check("beq2_pc_en", int'(pc_en), 0);

      // sw: mem_write, never reg_write
      opcode = 6'h2B;
      step(); step(); step(); step();
      check("memwr_state", int'(state_o), 8);
      check("memwr_sel", int'({mem_write, i_or_d, reg_write, mem_read}), 'b1100);
      step();
      check("sw_done", int'(state_o), 1);

      // jump
      opcode = 6'h02;
      step(); step();
      check("jump", int'({state_o, pc_en, pc_src}), 'b1010_1_10);

      // addi
      opcode = 6'h08;
      step(); step(); step();
      check("addiex", int'({state_o, ALU_src_a, ALU_src_b}), 'b1011_1_10);
      step();
      check("addiwb", int'({state_o, reg_write, mem_to_reg, reg_dst}), 'b1100_1_0_0);

      // illegal opcode
      opcode = 6'h3F;
      step(); step();
      check("illegal_pulse", int'({state_o, illegal_op}), 'b0010_1);
      mem_ready = 1'b0;
      step();
      check("illegal_to_fetch", int'({state_o, illegal_op}), 'b0001_0);

      // timeout: 15 wait cycles tolerated, error on the 16th
      errs = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus_err || ir_write || pc_en || state_o != 4'd1) errs++;
         if (i < 14) step();
      end
      check("stall_quiet", errs, 0);
      step();
      check("bus_err", int'({bus_err, ir_write, pc_en, reg_write}), 'b1000);
      step();
      check("retry_fetch", int'({state_o, bus_err}), 'b0001_0);

      // mem_ready arriving exactly at the limit completes normally
      for (int i = 0; i < 15; i++) step();
      mem_ready = 1'b1;
      #1;
      check("limit_ready", int'({bus_err, ir_write, pc_en}), 'b011);
      step();
      check("limit_decode", int'(state_o), 2);

      // async abort in MEM_WR
      opcode = 6'h2B; mem_ready = 1'b0;
      step(); step();
      check("abort_pre", int'({state_o, mem_write}), 'b1000_1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_async", int'({state_o, mem_write}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
